// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined ALU among N requesters.
// Each issued op carries its requester ID down a tag pipe so the result is returned tagged.
module alu_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       cfg_mask,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*OPW-1:0]   req_op,
    input  logic [N*W-1:0]     req_a,
    input  logic [N*W-1:0]     req_b,
    output logic               alu_valid,
    output logic [OPW-1:0]     alu_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    input  logic [W-1:0]       alu_result,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_data
);

    localparam int IW = IDW + 1;
    localparam logic [IW-1:0] NW = IW'(N);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   elig;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IW-1:0]  idx_w;
    logic [IW-1:0]  nxt_w;
    logic           hs;

    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_a, sel_b;

    logic           alu_valid_q;
    logic [OPW-1:0] alu_op_q;
    logic [W-1:0]   alu_a_q, alu_b_q;

    logic [ALU_LAT:0] tag_v_q;
    logic [IDW-1:0]   tag_id_q [ALU_LAT+1];

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;

    assign elig = req_valid & cfg_mask;

    // Search ptr, ptr+1, ... modulo N; the first eligible requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx_w       = '0;
        for (int k = 0; k < N; k++) begin
            idx_w = {1'b0, ptr_q} + IW'(k);
            if (idx_w >= NW) begin
                idx_w = idx_w - NW;
            end
            if (!grant_found && elig[idx_w[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx_w[IDW-1:0];
            end
        end
    end

    assign hs = grant_found & ~rst;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IDW'(i)) begin
                req_ready[i] = hs;
                sel_op       = req_op[i*OPW +: OPW];
                sel_a        = req_a[i*W +: W];
                sel_b        = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        nxt_w = {1'b0, grant_id} + IW'(1);
        if (nxt_w >= NW) begin
            nxt_w = '0;
        end
        ptr_d = hs ? nxt_w[IDW-1:0] : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            tag_v_q     <= '0;
            for (int s = 0; s <= ALU_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            alu_valid_q <= hs;
            if (hs) begin
                alu_op_q <= sel_op;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
            end
            tag_v_q[0]  <= hs;
            tag_id_q[0] <= grant_id;
            for (int s = 1; s <= ALU_LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
            // Last tag stage lines up with the cycle alu_result is valid.
            rsp_valid_q <= tag_v_q[ALU_LAT];
            if (tag_v_q[ALU_LAT]) begin
                rsp_id_q   <= tag_id_q[ALU_LAT];
                rsp_data_q <= alu_result;
            end
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
